// File: rtl/commutation_sequencer_if.sv
// commutation_sequencer_if: request/sense inputs and gate-drive outputs of the commutation sequencer
interface commutation_sequencer_if;
  logic start;
  logic [1:0] load_req;
  logic cur_sign;
  logic short_in;
  logic fault_clr;
  logic [5:0] sout;
  logic [1:0] active_load;
  logic busy;
  logic fault;
  modport master (
    output start, load_req, cur_sign, short_in, fault_clr,
    input sout, active_load, busy, fault
  );
  modport slave (
    input start, load_req, cur_sign, short_in, fault_clr,
    output sout, active_load, busy, fault
  );
endinterface

// File: rtl/commutation_sequencer.sv
// commutation_sequencer: four-step current-sign commutation for a 3-pair bidirectional switch matrix
// Optional SHORT_DEGLITCH_EN: short trip and fault clear need two consecutive agreeing short_in samples.
module commutation_sequencer #(
  parameter int STEP_CYCLES = 4,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  commutation_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ON, STEP1, STEP2, STEP3, STEP4, FAULT} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0] x, x_n, y, y_n, al_n, d;
  logic s, s_n, last, trip, clr_ok;
  logic [5:0] sout_n;
  function automatic logic [5:0] place(input logic [1:0] l, input logic [1:0] b);
    return l == 2'd1 ? {b, 4'b0} : l == 2'd2 ? {2'b0, b, 2'b0} : l == 2'd3 ? {4'b0, b} : 6'b0;
  endfunction
`ifdef SHORT_DEGLITCH_EN
  logic short_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) short_q <= 1'b0;
    else short_q <= bus.short_in;
  assign trip = bus.short_in & short_q;
  assign clr_ok = bus.fault_clr & ~bus.short_in & ~short_q;
`else
  assign trip = bus.short_in;
  assign clr_ok = bus.fault_clr & ~bus.short_in;
`endif
  assign last = cnt == CNT_W'(STEP_CYCLES - 1);
  assign d = s_n ? 2'b10 : 2'b01;
  always_comb begin
    state_n = state;
    cnt_n = '0;
    x_n = x;
    y_n = y;
    s_n = s;
    al_n = bus.active_load;
    if (trip) begin
      state_n = FAULT;
      al_n = 2'b00;
    end else begin
      case (state)
        IDLE: if (bus.start && bus.load_req != 2'b00) begin
          state_n = ON;
          al_n = bus.load_req;
        end
        ON: if (!bus.start || bus.load_req == 2'b00) begin
          state_n = IDLE;
          al_n = 2'b00;
        end else if (bus.load_req != bus.active_load) begin
          state_n = STEP1;
          x_n = bus.active_load;
          y_n = bus.load_req;
          s_n = bus.cur_sign;
        end
        STEP1, STEP2, STEP3: begin
          state_n = last ? state_t'(state + 3'd1) : state;
          cnt_n = last ? '0 : cnt + CNT_W'(1);
        end
        STEP4: begin
          state_n = last ? ON : STEP4;
          cnt_n = last ? '0 : cnt + CNT_W'(1);
          al_n = last ? y : bus.active_load;
        end
        FAULT: state_n = clr_ok ? IDLE : FAULT;
        default: state_n = IDLE;
      endcase
    end
  end
  // Gate pattern derived from the next state so every output stays registered.
  always_comb begin
    sout_n = '0;
    case (state_n)
      ON: sout_n = place(al_n, 2'b11);
      STEP1: sout_n = place(x_n, d);
      STEP2: sout_n = place(x_n, d) | place(y_n, d);
      STEP3: sout_n = place(y_n, d);
      STEP4: sout_n = place(y_n, 2'b11);
      default: sout_n = '0;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      x <= '0;
      y <= '0;
      s <= 1'b0;
      bus.sout <= '0;
      bus.active_load <= '0;
      bus.busy <= 1'b0;
      bus.fault <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      x <= x_n;
      y <= y_n;
      s <= s_n;
      bus.sout <= sout_n;
      bus.active_load <= al_n;
      bus.busy <= state_n inside {STEP1, STEP2, STEP3, STEP4};
      bus.fault <= state_n == FAULT;
    end
  logic [2:0] full;
  logic [5:0] xy_mask;
  assign full = {&bus.sout[5:4], &bus.sout[3:2], &bus.sout[1:0]};
  assign xy_mask = place(x, 2'b11) | place(y, 2'b11);
  a_one_pair: assert property (@(posedge clk) disable iff (rst) $onehot0(full));
  a_one_dev: assert property (@(posedge clk) disable iff (rst)
    state inside {STEP1, STEP2, STEP3} |-> full == 3'b000);
  a_conduct: assert property (@(posedge clk) disable iff (rst) bus.busy |-> |(bus.sout & xy_mask));
endmodule

// File: doc/commutation_sequencer.md
Name: commutation_sequencer

Overview:
- Four-step current-sign commutation controller for the 3-way bidirectional switch matrix (loads AA, BB, CC).
- Takes a requested load, the sensed current sign and the short-circuit flag, and produces the six gate drives.
- The outgoing load is never released before the incoming load conducts, and the matrix never presents a direct line-to-line short.
- Sits between the load-selection logic and the gate drivers; replaces abrupt pair-to-pair switching.

Parameters:
STEP_CYCLES, 4, clock cycles each commutation step is held (>=1)
CNT_W, 8, width of the step dwell counter (must hold STEP_CYCLES-1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  enable; level-sensitive
load_req  input  2  requested load: 00 none, 01 AA, 10 BB, 11 CC
cur_sign  input  1  load current sign: 1 forward, 0 reverse
short_in  input  1  short-circuit detect, active high
fault_clr  input  1  clears latched fault
sout  output  6  gate drives, registered; [5:4] AA, [3:2] BB, [1:0] CC; within a pair the upper bit is the forward device, the lower bit the reverse device
active_load  output  2  load currently fully conducting (00 = none)
busy  output  1  high while commutating
fault  output  1  latched short fault

Behaviour:
- Reset (async, rst=1): state IDLE, sout=000000, active_load=00, busy=0, fault=0, dwell counter=0.
- All outputs are registered; every change appears on the clk edge after the deciding inputs are sampled.
- States: IDLE, ON, STEP1, STEP2, STEP3, STEP4, FAULT.
- IDLE: sout=0.
  - start=1 and load_req!=00: next edge enters ON, the requested pair is fully on (11), and active_load=load_req.
  - start=0 or load_req=00: remain in IDLE.
- ON:
  - start=0 or load_req=00: next edge enters IDLE with sout=0 and active_load=00.
  - load_req!=active_load (nonzero): capture target Y, source X=active_load and sign s=cur_sign, set busy=1, enter STEP1.
  - load_req==active_load: hold.
- Commutation patterns, X to Y, with d = forward device if s=1, reverse device if s=0:
  - STEP1: X conducts d only; Y off.
  - STEP2: X d on; Y d on.
  - STEP3: X off; Y d only.
  - STEP4: Y both on.
  - Each step is held exactly STEP_CYCLES cycles. After STEP4 the block enters ON with active_load=Y and busy=0.
  - Total latency: 4*STEP_CYCLES cycles from the sampling edge to ON.
- Changes to cur_sign, load_req or start during STEP1-STEP4 are ignored. Inputs are re-evaluated on the first ON cycle, so a pending new request commutes again immediately and start=0 turns the matrix off.
- Short (highest priority, from any state): short_in=1 at an edge forces FAULT on that edge.
  - In FAULT: sout=0, active_load=00, busy=0, fault=1.
- FAULT exits to IDLE only when fault_clr=1 and short_in=0 at the same edge. If both short_in=1 and fault_clr=1, the block stays in FAULT.
- Invariants, checked in every cycle:
  - No two pairs fully on simultaneously.
  - Never more than one device per pair on during STEP1-STEP3.
  - At least one device of X or Y on throughout a commutation.
- Reset asserted mid-commutation: outputs go to 0 immediately (async).

Optional Feature:
Macro SHORT_DEGLITCH_EN.
- Defined: short_in must be sampled high on two consecutive edges to enter FAULT. FAULT is entered on the second edge, and a single-cycle pulse is ignored. fault_clr additionally requires two consecutive low samples of short_in.
- Undefined: a single high sample trips FAULT on that edge.

Test Plan:
1. Reset, then start=0 with load_req=01 for 5 cycles -> sout=000000, active_load=00. Then set start=1 -> sout=110000, active_load=01 one cycle later.
2. In ON AA with cur_sign=1 and STEP_CYCLES=4, request 10 -> sout=100000 (4 cycles), 101000 (4), 001000 (4), then 001100. busy=1 for 16 cycles, then active_load=10.
3. Same as scenario 2 with cur_sign=0 and a request from BB to AA -> sout=000100, 010100, 010000, then 110000. Toggling cur_sign mid-sequence does not alter the pattern.
4. In ON AA, pulse short_in for 1 cycle -> sout=000000 and fault=1 on that edge (with SHORT_DEGLITCH_EN: no fault). Set load_req=11 and hold the fault -> remains 000000. Pulse fault_clr -> IDLE, then 000011 the next cycle.
5. Assert short_in during STEP2 -> immediate 000000 with fault=1. Assert rst mid-STEP3 -> all outputs 0 asynchronously.
6. Request CC during a commutation from AA to BB -> the block finishes at BB (001100), then starts BB to CC on the next cycle.
